// File: rtl/cache_ctrl_fsm.sv
// Write-back, write-allocate cache controller: hit/miss sequencing, victim writeback,
// word-serial line refill and saturating hit/miss performance counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// COMPARE   | tag check; hits complete in zero cycles, misses start a refill
// WRITEBACK | streaming dirty victim words to memory
// ALLOCATE  | streaming refill words from memory into the victim way
// FILL_DONE | mark victim valid/clean, then replay the access in COMPARE
module cache_ctrl_fsm #(
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic             hit,
    input  logic             victim_dirty,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [IDX_W-1:0] word_idx,
    output logic             update,
    output logic             refill_done,
    output logic             set_dirty,
    output logic             lru_update,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE, FILL_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [IDX_W-1:0] word_idx_nxt;
    logic             last_word;
    logic             access_hit;
    logic             access_miss;

    assign last_word   = (word_idx == LAST_WORD);
    assign access_hit  = (state == COMPARE) && req_valid && hit;
    assign access_miss = (state == COMPARE) && req_valid && !hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= COMPARE;
            word_idx <= '0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        case (state)
            COMPARE: begin
                if (access_miss) begin
                    word_idx_nxt = '0;
                    state_nxt    = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    if (last_word) begin
                        word_idx_nxt = '0;
                        state_nxt    = ALLOCATE;
                    end else begin
                        word_idx_nxt = word_idx + IDX_W'(1);
                    end
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    if (last_word) begin
                        word_idx_nxt = '0;
                        state_nxt    = FILL_DONE;
                    end else begin
                        word_idx_nxt = word_idx + IDX_W'(1);
                    end
                end
            end
            FILL_DONE: state_nxt = COMPARE;
            default:   state_nxt = COMPARE;
        endcase
    end

    // Strobes are forced low while RST is high so memory traffic stops without waiting for a clock.
    always_comb begin
        pc_stall    = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        update      = 1'b0;
        refill_done = 1'b0;
        set_dirty   = 1'b0;
        lru_update  = 1'b0;
        if (!RST) begin
            case (state)
                COMPARE: begin
                    pc_stall   = access_miss;
                    lru_update = access_hit;
                    set_dirty  = access_hit && req_we;
                end
                WRITEBACK: begin
                    pc_stall = 1'b1;
                    mem_wr   = 1'b1;
                end
                ALLOCATE: begin
                    pc_stall = 1'b1;
                    mem_rd   = 1'b1;
                    update   = mem_ready;
                end
                FILL_DONE: begin
                    pc_stall    = 1'b1;
                    refill_done = 1'b1;
                end
                default: pc_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (access_hit && (hit_cnt != CNT_MAX))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (access_miss && (miss_cnt != CNT_MAX))
                miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

endmodule
